// File: rtl/hh_array.sv
// rtl/hh_array.sv - time-multiplexed array of reduced Hodgkin-Huxley neurons
// One shared datapath sweeps every channel per accepted step.
module hh_array #(
    parameter int W       = 8,
    parameter int N_CH    = 4,
    parameter int THRESH  = 150,
    parameter int V_RESET = 20,
    parameter int E_NA    = 240,
    parameter int E_K     = 0,
    parameter int E_L     = 20,
    parameter int DT_SH   = 2,
    parameter int L_SH    = 2,
    parameter int M_SH    = 1,
    parameter int H_SH    = 3,
    parameter int N_SH    = 4,
    parameter int REFRAC  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_valid,
    output logic                step_ready,
    input  logic [N_CH*W-1:0]   stim_current,
    output logic [N_CH*W-1:0]   membrane,
    output logic [N_CH-1:0]     spike,
    output logic                busy,
    output logic                done
);

    localparam int AW  = 2 * W + 4;
    localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic signed [AW-1:0] ENA  = AW'(E_NA);
    localparam logic signed [AW-1:0] EK   = AW'(E_K);
    localparam logic signed [AW-1:0] EL   = AW'(E_L);
    localparam logic signed [AW-1:0] VMAX = AW'((1 << W) - 1);
    localparam logic [W-1:0]         VR   = W'(V_RESET);
    localparam logic [W-1:0]         THR  = W'(THRESH);
    localparam logic [IW-1:0]        LAST = IW'(N_CH - 1);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic               busy_q;
    logic               done_q;
    logic [N_CH-1:0]    spike_q;
    logic [N_CH-1:0]    shadow_q;
    logic [W-1:0]       v_q    [N_CH];
    logic [W-1:0]       m_q    [N_CH];
    logic [W-1:0]       h_q    [N_CH];
    logic [W-1:0]       n_q    [N_CH];
    logic [RCW-1:0]     rc_q   [N_CH];
    logic [W-1:0]       stim_q [N_CH];

    logic [W-1:0]       v_c, m_c, h_c, n_c, s_c;
    logic [RCW-1:0]     rc_c;
    logic [W-1:0]       mm, mmm, gna, nn, gk;
    logic signed [AW-1:0] i_na, i_k, i_l, dv, vn;
    logic [W-1:0]       vn_c;
    logic [W-1:0]       v_d, m_d, h_d, n_d;
    logic [RCW-1:0]     rc_d;
    logic               spk_d;
    logic [N_CH-1:0]    shadow_d;

    // Fractional product of two unsigned W-bit quantities.
    function automatic logic [W-1:0] p(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> W);
    endfunction

    function automatic logic signed [AW-1:0] ext(input logic [W-1:0] x);
        return $signed({{(AW-W){1'b0}}, x});
    endfunction

    function automatic logic [W-1:0] clampw(input logic signed [AW-1:0] x);
        if (x[AW-1])
            return '0;
        else if (x > VMAX)
            return '1;
        else
            return x[W-1:0];
    endfunction

    always_comb begin
        v_c  = v_q[idx_q];
        m_c  = m_q[idx_q];
        h_c  = h_q[idx_q];
        n_c  = n_q[idx_q];
        rc_c = rc_q[idx_q];
        s_c  = stim_q[idx_q];

        mm   = p(m_c, m_c);
        mmm  = p(mm, m_c);
        gna  = p(mmm, h_c);
        nn   = p(n_c, n_c);
        gk   = p(nn, nn);

        i_na = (ext(gna) * (ENA - ext(v_c))) >>> W;
        i_k  = (ext(gk) * (ext(v_c) - EK)) >>> W;
        i_l  = (ext(v_c) - EL) >>> L_SH;
        dv   = ext(s_c) + i_na - i_k - i_l;
        vn   = ext(v_c) + (dv >>> DT_SH);
        vn_c = clampw(vn);

        m_d  = clampw(ext(m_c) + ((ext(v_c) - ext(m_c)) >>> M_SH));
        h_d  = clampw(ext(h_c) + (((VMAX - ext(v_c)) - ext(h_c)) >>> H_SH));
        n_d  = clampw(ext(n_c) + ((ext(v_c) - ext(n_c)) >>> N_SH));

        // Refractory channels are pinned at reset voltage but gates still relax.
        v_d   = vn_c;
        rc_d  = rc_c;
        spk_d = 1'b0;
        if (rc_c != '0) begin
            v_d  = VR;
            rc_d = rc_c - RCW'(1);
        end else if (vn_c >= THR) begin
            v_d   = VR;
            rc_d  = RCW'(REFRAC);
            spk_d = 1'b1;
        end

        shadow_d        = shadow_q;
        shadow_d[idx_q] = spk_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            spike_q  <= '0;
            shadow_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                v_q[c]    <= VR;
                m_q[c]    <= '0;
                h_q[c]    <= '1;
                n_q[c]    <= '0;
                rc_q[c]   <= '0;
                stim_q[c] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (step_valid) begin
                        for (int c = 0; c < N_CH; c++)
                            stim_q[c] <= stim_current[c*W +: W];
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    v_q[idx_q]  <= v_d;
                    m_q[idx_q]  <= m_d;
                    h_q[idx_q]  <= h_d;
                    n_q[idx_q]  <= n_d;
                    rc_q[idx_q] <= rc_d;
                    shadow_q    <= shadow_d;
                    if (idx_q == LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        spike_q <= shadow_d;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        membrane = '0;
        for (int c = 0; c < N_CH; c++)
            membrane[c*W +: W] = v_q[c];
    end

    assign step_ready = ~busy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign spike      = spike_q;

endmodule

// File: doc/hh_array.md
# hh_array

Time-multiplexed array of N_CH reduced Hodgkin-Huxley neurons sharing one arithmetic datapath. Each accepted step updates membrane voltage and m/h/n gating variables of every channel in sequence, applies threshold/refractory logic, and reports per-channel spikes. Successor to the single-neuron hh core. Adds parametrised width and channel count, evolving gates, saturation, refractory period and a step handshake. Sits between the stimulus front-end and the spike encoder.

## Interface
Parameters:
- W, 8: data width of voltage, gates, stimulus (unsigned).
- N_CH, 4: number of neuron channels (≥1).
- THRESH, 150: spike threshold on V.
- V_RESET, 20: post-spike and reset voltage.
- E_NA, 240; E_K, 0; E_L, 20: reversal potentials.
- DT_SH, 2: integration shift on dV.
- L_SH, 2: leak conductance shift.
- M_SH, 1; H_SH, 3; N_SH, 4: gate relaxation shifts.
- REFRAC, 3: refractory length in steps.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- step_valid  in  1  request one integration step.
- step_ready  out  1  high when idle (= !busy).
- stim_current  in  N_CH*W  per-channel stimulus; channel c at bits [c*W +: W].
- membrane  out  N_CH*W  registered per-channel V.
- spike  out  N_CH  per-channel spike flags from last completed step.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.

## Operation
- Per-channel state: V, m, h, n (W bits), refractory counter rc (≥ clog2(REFRAC+1) bits).
- Reset: V=V_RESET, m=0, h=2^W−1, n=0, rc=0. Outputs: membrane all V_RESET, spike=0, busy=0, done=0, step_ready=1.
- States: IDLE, SWEEP. IDLE + step_valid → latch stim_current, idx=0, SWEEP. SWEEP updates channel idx per cycle. After idx=N_CH−1 → IDLE, done pulse.
- Per-channel update uses only old values of that channel. p(a,b) = (a*b)>>W:
  - g_na = p(p(p(m,m),m),h); g_k = p(p(n,n),p(n,n)).
  - I_na = (g_na*(E_NA−V))>>>W; I_k = (g_k*(V−E_K))>>>W; I_l = (V−E_L)>>>L_SH.
  - dV = stim + I_na − I_k − I_l; Vn = clamp(V + (dV>>>DT_SH), 0, 2^W−1).
  - m += (V−m)>>>M_SH; h += ((2^W−1−V)−h)>>>H_SH; n += (V−n)>>>N_SH; each clamped to 0..2^W−1.
- Arithmetic: signed, wide enough that nothing wraps before the clamp (≥2W+3 bits). >>> is an arithmetic shift that floors (−20>>>3 = −3).
- Spike/refractory:
  - If rc>0: store V=V_RESET, rc−1, spike bit 0.
  - Else if Vn ≥ THRESH: store V=V_RESET, rc=REFRAC, spike bit 1.
  - Else: store V=Vn, spike bit 0.
  - Gates update in all three cases.
- Spike bits accumulate in a shadow vector. spike output loads from it on the completing edge and holds until the next completion.

## Timing
- Accept at edge T when step_valid && step_ready. Stimulus is sampled only at T, so later changes do not affect the sweep.
- Channel k is written at edge T+1+k. membrane[k] is visible from cycle T+2+k.
- At edge T+N_CH: busy←0, done←1 for exactly one cycle, spike vector updated. Accept-to-done latency is N_CH+1 edges (busy set at T, done visible after T+N_CH).
- step_valid while busy is ignored, not queued.
- A step is accepted in the cycle done is high. Back-to-back period is N_CH+1 cycles.
- rst at any cycle, including mid-SWEEP, restores all reset values on that edge. The partial sweep is discarded with no done pulse.

## Test plan
- Reset:
  - Stimulus: assert rst 2 cycles.
  - Required: membrane = {4{20}}, spike=0, busy=0, done=0, step_ready=1.
- Rest step:
  - Stimulus: stim=0 on all channels, one step.
  - Required: membrane stays 20 on all channels; internal m=10, h=252, n=1; done exactly 5 edges after accept; spike=0.
- Single drive:
  - Stimulus: stim ch0=255, others 0, one step from reset.
  - Required: membrane[0]=83, others 20; membrane[0] changes one cycle before membrane[1] would.
- Spike and refractory:
  - Stimulus: ch0 stim=255 held over repeated steps.
  - Required: first step with Vn≥150 gives spike[0]=1 for exactly one step and membrane[0]=20. The next 3 steps hold membrane[0]=20 with spike[0]=0. Rise resumes on the 4th step.
- Saturation:
  - Stimulus: DT_SH=0, stim ch0=255 from reset.
  - Required: Vn clamps to 255 (not wrapped to 19) → spike[0]=1, membrane[0]=20.
- Handshake/reset abort:
  - Stimulus: step_valid held high continuously.
  - Required: accepts every 5 cycles; none accepted while busy.
  - Stimulus: rst during the 3rd sweep cycle.
  - Required: no done, all reset values restored next cycle.
